ext_link_peer: RTL and testbench
================================

// Module: ext_link_peer
// PURPOSE
//  Far-end endpoint of the two-wire inter-board serial link (link_tx/link_rx) served by ext_interface.
//  Turns a parallel 10-bit frame ({prefix[1:0], data[7:0]}) into a link transfer and back.
//  Tx path: baud-calibration pulse, ack, start bit, 10 bits MSB first, ack.
//  Rx path: measures the incoming calibration pulse, acks, samples the frame, acks.
//  Feeds ext_interface's rx and consumes its tx; used on the peer board and as the bench driver.
// PARAMETERS
//  BAUD_SIZE    16'd8     clocks per bit when this block initiates (tx path)
//  FRAME_WIDTH  10        bits per frame; fixed at 10, constant lives in package
//  ACK_TIMEOUT  16'd1024  clocks to wait for any peer edge before aborting
//  MIN_BAUD     16'd2     shortest calibration pulse accepted; shorter = glitch
// PORTS
//  clk        in   1   clock
//  rstn       in   1   reset, asynchronous, active-low
//  link_tx    out  1   serial out, idles high
//  link_rx    in   1   serial in, idles high; asynchronous, synchronised internally
//  tx_valid   in   1   frame request
//  tx_frame   in   10  frame to send; captured when tx_valid & tx_ready
//  tx_ready   out  1   high only in IDLE with no rx activity
//  tx_done    out  1   1-clk pulse after closing ack received
//  tx_err     out  1   1-clk pulse on ack timeout
//  rx_valid   out  1   1-clk pulse; rx_frame valid that cycle and held until next frame
//  rx_frame   out  10  last received frame
//  rx_err     out  1   1-clk pulse on rx timeout (no start bit)
//  busy       out  1   state != IDLE
//  state      out  5   current FSM state, for debug
// BEHAVIOUR
//  Reset values:
//   - link_tx=1, tx_ready=0 in reset cycle then 1, all pulses 0.
//   - rx_frame=0, busy=0, state=IDLE.
//  Synchroniser: link_rx passes through a 2-flop synchroniser (rx_s).
//   - All rx timing is relative to rx_s; the constant 2-clk lag does not affect baud measurement.
//  Single FSM, one transfer at a time. In IDLE, rx_s==0 has priority over tx_valid in the same cycle.
//  Tx path (baud B = BAUD_SIZE):
//   - T_CAL: link_tx=0 for B clks, then 1.
//   - T_ACK1: wait rx_s==0. T_ACK2: wait rx_s==1.
//   - T_GAP: B clks high.
//   - T_START: link_tx=0 for B clks.
//   - T_BITS: tx_frame[9] down to [0], B clks each. Bit counter 4b, ends at 0.
//   - Then link_tx=1.
//   - T_FACK1/T_FACK2: wait rx_s low then high; pulse tx_done; go to IDLE.
//  Rx path:
//   - R_CAL: count clks while rx_s==0 into meas (16b, saturates at 16'hFFFF).
//   - On rx_s rising: if meas<MIN_BAUD go to IDLE silently; else M=meas.
//   - R_GAP: M clks, then link_tx=0 for M clks (R_ACK), then link_tx=1.
//   - R_WSTART: wait rx_s==0.
//   - R_HALF: wait M>>1 clks.
//   - R_BITS: every M clks sample rx_s into frame[9..0], MSB first.
//   - R_TAIL: wait 2*M clks after last sample.
//   - R_FACK: link_tx=0 for M clks; at entry, load rx_frame and pulse rx_valid.
//   - Then link_tx=1; go to IDLE.
//  Timeouts:
//   - Every "wait for rx_s edge" state runs a counter reset on entry.
//   - Reaching ACK_TIMEOUT forces link_tx=1 and returns to IDLE.
//   - In tx states this pulses tx_err; in rx states it pulses rx_err.
//  Width rules:
//   - Bit timer 16b, compared with ==; M>>1 truncates.
//   - M=1 is legal only if MIN_BAUD<=1; half-wait of 0 samples on the next clk.
//  Mid-operation events:
//   - tx_valid during busy is ignored; the requester holds it.
//   - Reset mid-transfer returns to IDLE and drives link_tx=1 immediately (asynchronous).
//  Illegal state encodings go to IDLE.
// STRUCTURE
//  Package ext_link_pkg holds:
//   - state enum (5b): IDLE, T_CAL..T_FACK2, R_CAL..R_FACK.
//   - FRAME_WIDTH=10 and prefix localparams.
//  Sub-module baud_timer (one per instance) provides:
//   - 16b counter with load, is_half, is_full, timeout flag.
//   - The FSM shares it between tx and rx paths.
// TESTING
//  1. Loopback to ext_interface (BAUD 8): tx_frame=10'h0A5 -> its slave path sees data 8'hA5; tx_done in one transfer.
//  2. Rx from ext_interface: slave read of 8'h3C, prefix 2'b00 -> rx_valid once, rx_frame=10'h03C.
//  3. Rx baud sweep: model sends pulses of 3, 8 and 100 clks -> correct frame 10'h2AA each time.
//  4. Glitch: rx_s low 1 clk (MIN_BAUD=2) -> back to IDLE, no ack, no rx_valid/rx_err.
//  5. Silent peer: tx_frame sent, link_rx held high -> tx_err after ACK_TIMEOUT+B clks, link_tx=1, tx_ready=1.
//  6. Collision and reset: rx falls the same clk tx_valid rises -> rx wins, tx sent afterwards.
//     Then rstn low mid-T_BITS -> link_tx=1, busy=0 at once.

Source files
------------

// File: rtl/ext_link_pkg.sv
// Shared types and constants for the inter-board serial link endpoint.
package ext_link_pkg;
    localparam int         FRAME_WIDTH = 10;
    localparam logic [3:0] LAST_BIT    = 4'(FRAME_WIDTH - 1);
    localparam int         PFX_W       = 2;
    localparam logic [1:0] PFX_DATA    = 2'b00;

    typedef enum logic [4:0] {
        IDLE     = 5'd0,
        T_CAL    = 5'd1,
        T_ACK1   = 5'd2,
        T_ACK2   = 5'd3,
        T_GAP    = 5'd4,
        T_START  = 5'd5,
        T_BITS   = 5'd6,
        T_FACK1  = 5'd7,
        T_FACK2  = 5'd8,
        R_CAL    = 5'd9,
        R_GAP    = 5'd10,
        R_ACK    = 5'd11,
        R_WSTART = 5'd12,
        R_HALF   = 5'd13,
        R_BITS   = 5'd14,
        R_TAIL   = 5'd15,
        R_FACK   = 5'd16
    } state_t;

    function automatic logic is_tx_state(input state_t s);
        return s inside {T_CAL, T_ACK1, T_ACK2, T_GAP, T_START, T_BITS, T_FACK1, T_FACK2};
    endfunction
endpackage

// File: rtl/ext_link_peer_baud_timer.sv
// Free-running bit timer; restart makes the current cycle count as zero.
module baud_timer #(
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        restart,
    input  logic [15:0] period,
    output logic        is_half,
    output logic        is_full,
    output logic        timeout
);
    logic [15:0] cnt, cur, half;

    assign cur     = restart ? 16'd0 : cnt;
    assign half    = period >> 1;
    assign is_full = (cur == period - 16'd1);
    // A zero half-period fires on the first cycle rather than never.
    assign is_half = (half == 16'd0) || (cur == half - 16'd1);
    assign timeout = (cur == ACK_TIMEOUT - 16'd1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt <= '0;
        else       cnt <= cur + 16'd1;
    end
endmodule

// File: rtl/ext_link_peer.sv
// Far-end endpoint of the two-wire serial link: parallel frame <-> calibrated serial transfer.
module ext_link_peer
    import ext_link_pkg::*;
#(
    parameter logic [15:0] BAUD_SIZE   = 16'd8,
    parameter logic [15:0] ACK_TIMEOUT = 16'd1024,
    parameter logic [15:0] MIN_BAUD    = 16'd2
) (
    input  logic                   clk,
    input  logic                   rstn,
    output logic                   link_tx,
    input  logic                   link_rx,
    input  logic                   tx_valid,
    input  logic [FRAME_WIDTH-1:0] tx_frame,
    output logic                   tx_ready,
    output logic                   tx_done,
    output logic                   tx_err,
    output logic                   rx_valid,
    output logic [FRAME_WIDTH-1:0] rx_frame,
    output logic                   rx_err,
    output logic                   busy,
    output logic [4:0]             state
);
    state_t                 st;
    logic                   rx_m, rx_s, ready_q, restart;
    logic [15:0]            m, period;
    logic [3:0]             bitcnt;
    logic [FRAME_WIDTH-1:0] txsh, rxsh;
    logic                   is_half, is_full, timeout;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) {rx_m, rx_s} <= 2'b11;
        else       {rx_m, rx_s} <= {link_rx, rx_m};
    end

    // Tx path runs at our own baud; rx path at the measured calibration width.
    assign period   = is_tx_state(st) ? BAUD_SIZE : m;
    assign tx_ready = ready_q && (st == IDLE) && rx_s;
    assign busy     = (st != IDLE);
    assign state    = st;

    baud_timer #(.ACK_TIMEOUT(ACK_TIMEOUT)) u_timer (
        .clk(clk), .rstn(rstn), .restart(restart), .period(period),
        .is_half(is_half), .is_full(is_full), .timeout(timeout)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st <= IDLE;  link_tx <= 1'b1;  ready_q <= 1'b0;  restart <= 1'b0;
            m <= '0;  bitcnt <= '0;  txsh <= '0;  rxsh <= '0;  rx_frame <= '0;
            tx_done <= 1'b0;  tx_err <= 1'b0;  rx_valid <= 1'b0;  rx_err <= 1'b0;
        end else begin
            ready_q  <= 1'b1;
            restart  <= 1'b0;
            tx_done  <= 1'b0;
            tx_err   <= 1'b0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (st)
                IDLE: begin
                    if (!rx_s) begin
                        st <= R_CAL;
                        m  <= 16'd1;
                    end else if (tx_valid && ready_q) begin
                        txsh <= tx_frame;  link_tx <= 1'b0;  st <= T_CAL;  restart <= 1'b1;
                    end
                end
                T_CAL:   if (is_full) begin link_tx <= 1'b1; st <= T_ACK1; restart <= 1'b1; end
                T_ACK1: begin
                    if (!rx_s)        begin st <= T_ACK2; restart <= 1'b1; end
                    else if (timeout) begin st <= IDLE; link_tx <= 1'b1; tx_err <= 1'b1; end
                end
                T_ACK2: begin
                    if (rx_s)         begin st <= T_GAP; restart <= 1'b1; end
                    else if (timeout) begin st <= IDLE; link_tx <= 1'b1; tx_err <= 1'b1; end
                end
                T_GAP:   if (is_full) begin link_tx <= 1'b0; st <= T_START; restart <= 1'b1; end
                T_START: if (is_full) begin
                    link_tx <= txsh[FRAME_WIDTH-1];
                    txsh    <= txsh << 1;
                    bitcnt  <= LAST_BIT;
                    st      <= T_BITS;
                    restart <= 1'b1;
                end
                T_BITS: if (is_full) begin
                    restart <= 1'b1;
                    if (bitcnt == 4'd0) begin
                        link_tx <= 1'b1;
                        st      <= T_FACK1;
                    end else begin
                        link_tx <= txsh[FRAME_WIDTH-1];
                        txsh    <= txsh << 1;
                        bitcnt  <= bitcnt - 4'd1;
                    end
                end
                T_FACK1: begin
                    if (!rx_s)        begin st <= T_FACK2; restart <= 1'b1; end
                    else if (timeout) begin st <= IDLE; link_tx <= 1'b1; tx_err <= 1'b1; end
                end
                T_FACK2: begin
                    if (rx_s)         begin st <= IDLE; tx_done <= 1'b1; end
                    else if (timeout) begin st <= IDLE; link_tx <= 1'b1; tx_err <= 1'b1; end
                end
                R_CAL: begin
                    if (!rx_s)              m  <= (m == 16'hFFFF) ? m : m + 16'd1;
                    else if (m < MIN_BAUD)  st <= IDLE;
                    else begin st <= R_GAP; restart <= 1'b1; end
                end
                R_GAP: if (is_full) begin link_tx <= 1'b0; st <= R_ACK; restart <= 1'b1; end
                R_ACK: if (is_full) begin link_tx <= 1'b1; st <= R_WSTART; restart <= 1'b1; end
                R_WSTART: begin
                    if (!rx_s)        begin st <= R_HALF; restart <= 1'b1; end
                    else if (timeout) begin st <= IDLE; link_tx <= 1'b1; rx_err <= 1'b1; end
                end
                R_HALF: if (is_half) begin st <= R_BITS; bitcnt <= LAST_BIT; restart <= 1'b1; end
                R_BITS: if (is_full) begin
                    rxsh    <= {rxsh[FRAME_WIDTH-2:0], rx_s};
                    restart <= 1'b1;
                    if (bitcnt == 4'd0) begin st <= R_TAIL; bitcnt <= 4'd1; end
                    else                bitcnt <= bitcnt - 4'd1;
                end
                // Two full bit periods of tail, counted on the bit counter to avoid 2*M overflow.
                R_TAIL: if (is_full) begin
                    restart <= 1'b1;
                    if (bitcnt == 4'd0) begin
                        st       <= R_FACK;
                        link_tx  <= 1'b0;
                        rx_frame <= rxsh;
                        rx_valid <= 1'b1;
                    end else begin
                        bitcnt <= bitcnt - 4'd1;
                    end
                end
                R_FACK: if (is_full) begin link_tx <= 1'b1; st <= IDLE; end
                default: begin st <= IDLE; link_tx <= 1'b1; end
            endcase
        end
    end
endmodule

// File: tb/tb_ext_link_peer.sv
// Scoreboard bench: bench-side link model drives/decodes the serial line around ext_link_peer.
module tb_ext_link_peer;
    localparam int B   = 8;
    localparam int ACK = 1024;

    logic       clk = 1'b0, rstn = 1'b0, link_rx = 1'b1, tx_valid = 1'b0;
    logic [9:0] tx_frame = '0;
    logic       link_tx, tx_ready, tx_done, tx_err, rx_valid, rx_err, busy;
    logic [9:0] rx_frame;
    logic [4:0] state;

    ext_link_peer dut (
        .clk(clk), .rstn(rstn), .link_tx(link_tx), .link_rx(link_rx),
        .tx_valid(tx_valid), .tx_frame(tx_frame), .tx_ready(tx_ready),
        .tx_done(tx_done), .tx_err(tx_err), .rx_valid(rx_valid),
        .rx_frame(rx_frame), .rx_err(rx_err), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    int         done_cnt = 0, txerr_cnt = 0, rxerr_cnt = 0, rxv_cnt = 0;
    logic [9:0] exp_rx[$], exp_tx[$];
    logic [9:0] mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops expected rx frames whenever the DUT presents one.
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid) begin
                rxv_cnt++;
                if (exp_rx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_frame);
                end else begin
                    mon_e = exp_rx.pop_front();
                    chk("rx_frame", 32'(rx_frame), 32'(mon_e));
                end
            end
            if (tx_done) done_cnt++;
            if (tx_err)  txerr_cnt++;
            if (rx_err)  rxerr_cnt++;
        end
    end

    task automatic wait_link(input logic lvl, input int max, input string name);
        int n = 0;
        while (link_tx !== lvl && n < max) begin @(negedge clk); n++; end
        if (link_tx !== lvl) begin
            checks++; errors++;
            $display("FAIL %s: timeout link_tx=%0b expected %0b", name, link_tx, lvl);
        end
    endtask

    task automatic measure_low(output int w, input int max);
        w = 0;
        while (link_tx === 1'b0 && w < max) begin @(negedge clk); w++; end
    endtask

    // Bench acts as the initiator: calibration pulse, ack, start, 10 bits, ack.
    task automatic send_frame(input int p, input logic [9:0] f);
        int w;
        exp_rx.push_back(f);
        @(negedge clk); link_rx = 1'b0;
        repeat (p) @(negedge clk);
        link_rx = 1'b1;
        wait_link(1'b0, 4*p + 40, "rx_ack_start");
        measure_low(w, 4*p + 40);
        chk("rx_ack_width", 32'(w), 32'(p));
        link_rx = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            link_rx = f[i];
            repeat (p) @(negedge clk);
        end
        link_rx = 1'b1;
        wait_link(1'b0, 3*p + 40, "rx_fack_start");
        measure_low(w, 4*p + 40);
        chk("rx_fack_width", 32'(w), 32'(p));
    endtask

    task automatic issue_tx(input logic [9:0] f, input bit expect_frame);
        int n = 0;
        if (expect_frame) exp_tx.push_back(f);
        tx_frame = f;
        tx_valid = 1'b1;
        while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
        if (!tx_ready) begin
            checks++; errors++;
            $display("FAIL tx_accept: timeout tx_ready=%0b expected 1", tx_ready);
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Bench acts as the receiver of the DUT's transmission.
    task automatic far_rx();
        int         w;
        logic [9:0] got, e;
        wait_link(1'b0, 5000, "tx_cal_start");
        measure_low(w, 200);
        chk("tx_cal_width", 32'(w), 32'(B));
        link_rx = 1'b0;
        repeat (B) @(negedge clk);
        link_rx = 1'b1;
        wait_link(1'b0, 200, "tx_start_bit");
        repeat (B + B/2) @(negedge clk);
        for (int i = 9; i >= 0; i--) begin
            got[i] = link_tx;
            if (i > 0) repeat (B) @(negedge clk);
        end
        repeat (B) @(negedge clk);
        chk("tx_line_idle", 32'(link_tx), 32'd1);
        if (exp_tx.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected: got %0h expected none", got);
        end else begin
            e = exp_tx.pop_front();
            chk("tx_frame", 32'(got), 32'(e));
        end
        link_rx = 1'b0;
        repeat (B) @(negedge clk);
        link_rx = 1'b1;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 100) begin @(negedge clk); n++; end
        chk("tx_done_cnt", 32'(done_cnt), 32'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int lowseen;
        repeat (3) @(negedge clk);
        chk("rst_link_tx", 32'(link_tx), 32'd1);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rx_frame", 32'(rx_frame), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_pulses", 32'({tx_done, tx_err, rx_valid, rx_err}), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_tx_ready", 32'(tx_ready), 32'd1);

        // Tx of a data frame to a well-behaved receiver.
        fork
            issue_tx(10'h0A5, 1'b1);
            far_rx();
        join
        wait_done(1);
        repeat (5) @(negedge clk);

        // Rx of a data read, then a baud sweep.
        send_frame(8, 10'h03C);
        repeat (5) @(negedge clk);
        chk("rx_valid_once", 32'(rxv_cnt), 32'd1);
        send_frame(3, 10'h2AA);
        repeat (5) @(negedge clk);
        send_frame(8, 10'h2AA);
        repeat (5) @(negedge clk);
        send_frame(100, 10'h2AA);
        repeat (5) @(negedge clk);
        chk("rx_valid_sweep", 32'(rxv_cnt), 32'd4);

        // One-clock glitch must be dropped without ack.
        @(negedge clk); link_rx = 1'b0;
        @(negedge clk); link_rx = 1'b1;
        lowseen = 0;
        repeat (40) begin @(negedge clk); if (link_tx === 1'b0) lowseen++; end
        chk("glitch_no_ack", 32'(lowseen), 32'd0);
        chk("glitch_rx_valid", 32'(rxv_cnt), 32'd4);
        chk("glitch_rx_err", 32'(rxerr_cnt), 32'd0);
        chk("glitch_state", 32'(state), 32'd0);

        // Silent peer: cal B clks, then ACK clks of waiting, then abort.
        issue_tx(10'h155, 1'b0);
        n = 1;
        while (!tx_err && n < 3000) begin @(negedge clk); n++; end
        chk("tx_err_latency", 32'(n), 32'(ACK + B + 1));
        chk("tx_err_link_tx", 32'(link_tx), 32'd1);
        chk("tx_err_tx_ready", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Collision: rx_s falls the same clock tx_valid rises; rx first, then tx.
        fork
            begin send_frame(8, 10'h155); far_rx(); end
            begin
                repeat (3) @(negedge clk);
                chk("collide_tx_ready", 32'(tx_ready), 32'd0);
                issue_tx(10'h2C3, 1'b1);
            end
        join
        wait_done(2);
        repeat (5) @(negedge clk);

        // Reset in the middle of the data bits.
        issue_tx(10'h000, 1'b0);
        wait_link(1'b0, 200, "rst_cal");
        measure_low(n, 200);
        link_rx = 1'b0;
        repeat (B) @(negedge clk);
        link_rx = 1'b1;
        wait_link(1'b0, 200, "rst_start");
        repeat (4*B) @(negedge clk);
        chk("mid_bits_busy", 32'(busy), 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid_link_tx", 32'(link_tx), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 32'(tx_ready), 32'd1);

        chk("end_tx_err_cnt", 32'(txerr_cnt), 32'd1);
        chk("end_rx_err_cnt", 32'(rxerr_cnt), 32'd0);
        chk("end_exp_rx_empty", 32'(exp_rx.size()), 32'd0);
        chk("end_exp_tx_empty", 32'(exp_tx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
